// File: rtl/counter_bank_pkg.sv
// Shared constants and per-channel command decode for the counter bank.
package counter_bank_pkg;

    localparam int NCH_DEF = 4;
    localparam int CW_DEF  = 8;
    localparam int DW_DEF  = 24;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_CLR  = 2'd1,
        CMD_INC  = 2'd2,
        CMD_DEC  = 2'd3
    } ch_cmd_e;

    // Clear beats everything; a disabled channel or an up/down collision holds.
    function automatic ch_cmd_e decode_cmd(input logic clr, input logic en, input logic up,
                                           input logic down, input logic auto_inc, input logic tick);
        if (clr)
            return CMD_CLR;
        if (!en || (up && down))
            return CMD_HOLD;
        if (up)
            return CMD_INC;
        if (down)
            return CMD_DEC;
        if (auto_inc && tick)
            return CMD_INC;
        return CMD_HOLD;
    endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: command decode, modulo/saturating count, registered event pulses.
// COUNTER_BANK_SATURATE_EN switches overflow/underflow from wrapping to saturation.
module counter_bank_ch
    import counter_bank_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic          up,
    input  logic          down,
    input  logic          auto_inc,
    input  logic          tick,
    input  logic [CW-1:0] cmp_val,
    output logic [CW-1:0] count,
    output logic          zero_pulse,
    output logic          cmp_pulse,
    output logic          wrap_pulse
);

    ch_cmd_e       cmd;
    logic [CW-1:0] count_nxt;
    logic          wrap_evt;
    logic          wrap_q;
    logic          zero_hist;
    logic          cmp_hist;
    logic          zero_now;
    logic          cmp_now;

    assign cmd      = decode_cmd(clr, en, up, down, auto_inc, tick);
    assign zero_now = (count == '0);
    assign cmp_now  = (count == cmp_val);

    always_comb begin
        count_nxt = count;
        wrap_evt  = 1'b0;
        case (cmd)
            CMD_CLR: count_nxt = '0;
            CMD_INC: begin
                wrap_evt = &count;
`ifdef COUNTER_BANK_SATURATE_EN
                if (!wrap_evt)
                    count_nxt = count + 1'b1;
`else
                count_nxt = count + 1'b1;
`endif
            end
            CMD_DEC: begin
                wrap_evt = ~|count;
`ifdef COUNTER_BANK_SATURATE_EN
                if (!wrap_evt)
                    count_nxt = count - 1'b1;
`else
                count_nxt = count - 1'b1;
`endif
            end
            default: count_nxt = count;
        endcase
    end

    // History registers reset to 1 so nothing fires right after reset release.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            wrap_q     <= 1'b0;
            wrap_pulse <= 1'b0;
            zero_hist  <= 1'b1;
            cmp_hist   <= 1'b1;
            zero_pulse <= 1'b0;
            cmp_pulse  <= 1'b0;
        end else begin
            count      <= count_nxt;
            wrap_q     <= wrap_evt;
            wrap_pulse <= wrap_q;
            zero_hist  <= zero_now;
            cmp_hist   <= cmp_now;
            zero_pulse <= zero_now & ~zero_hist;
            cmp_pulse  <= cmp_now & ~cmp_hist;
        end
    end

endmodule

// File: rtl/counter_bank.sv
// Bank of NCH independent counters sharing one programmable tick divider.
// Define COUNTER_BANK_SATURATE_EN to make every channel saturate instead of wrap.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic [DW-1:0]     div_period,
    input  logic [NCH-1:0]    ch_clr,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    ch_up,
    input  logic [NCH-1:0]    ch_down,
    input  logic [NCH-1:0]    ch_auto,
    input  logic [NCH*CW-1:0] cmp_val,
    output logic [NCH*CW-1:0] count,
    output logic              tick,
    output logic [NCH-1:0]    zero_pulse,
    output logic [NCH-1:0]    cmp_pulse,
    output logic [NCH-1:0]    wrap_pulse
);

    logic [DW-1:0] div_cnt;

    // div_period is only sampled at reload, so a change lands at the next period.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == '0) begin
            div_cnt <= div_period;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt - 1'b1;
            tick    <= 1'b0;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        counter_bank_ch #(.CW(CW)) u_ch (
            .sys_clk   (sys_clk),
            .reset     (reset),
            .clr       (ch_clr[i]),
            .en        (ch_en[i]),
            .up        (ch_up[i]),
            .down      (ch_down[i]),
            .auto_inc  (ch_auto[i]),
            .tick      (tick),
            .cmp_val   (cmp_val[i*CW +: CW]),
            .count     (count[i*CW +: CW]),
            .zero_pulse(zero_pulse[i]),
            .cmp_pulse (cmp_pulse[i]),
            .wrap_pulse(wrap_pulse[i])
        );
    end

endmodule

// File: tb/tb_counter_bank.sv
// Randomized and directed bench for counter_bank with a per-cycle expected-response queue.
module tb_counter_bank;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int DW   = 24;
    localparam int MAXV = (1 << CW) - 1;
    localparam int W    = NCH*CW + 1 + 3*NCH;

    logic              sys_clk = 1'b0;
    logic              reset;
    logic [DW-1:0]     div_period;
    logic [NCH-1:0]    ch_clr, ch_en, ch_up, ch_down, ch_auto;
    logic [NCH*CW-1:0] cmp_val;
    logic [NCH*CW-1:0] count;
    logic              tick;
    logic [NCH-1:0]    zero_pulse, cmp_pulse, wrap_pulse;

    counter_bank #(.NCH(NCH), .CW(CW), .DW(DW)) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .div_period(div_period),
        .ch_clr    (ch_clr),
        .ch_en     (ch_en),
        .ch_up     (ch_up),
        .ch_down   (ch_down),
        .ch_auto   (ch_auto),
        .cmp_val   (cmp_val),
        .count     (count),
        .tick      (tick),
        .zero_pulse(zero_pulse),
        .cmp_pulse (cmp_pulse),
        .wrap_pulse(wrap_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: counts as plain integers, "was equal last cycle" flags, pending wraps.
    int m_cnt[NCH];
    bit m_z[NCH];
    bit m_c[NCH];
    bit m_wp[NCH];
    bit m_tick;
    int edge_n;
    int next_tick;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0;
            m_z[i]   = 1'b1;
            m_c[i]   = 1'b1;
            m_wp[i]  = 1'b0;
        end
        m_tick    = 1'b0;
        edge_n    = 0;
        next_tick = 1;
    endtask

    // Drive one cycle of commands, predict the state after the coming edge, then advance.
    task automatic step(input logic [NCH-1:0] clr, input logic [NCH-1:0] en, input logic [NCH-1:0] up,
                        input logic [NCH-1:0] dn, input logic [NCH-1:0] au, input logic [NCH*CW-1:0] cv);
        logic [NCH*CW-1:0] e_cnt;
        logic [NCH-1:0]    e_z, e_c, e_w;
        logic              e_t;
        int                d, nv, cvi;
        ch_clr = clr; ch_en = en; ch_up = up; ch_down = dn; ch_auto = au; cmp_val = cv;
        for (int i = 0; i < NCH; i++) begin
            cvi     = int'(cv[i*CW +: CW]);
            e_z[i]  = (m_cnt[i] == 0) && !m_z[i];
            m_z[i]  = (m_cnt[i] == 0);
            e_c[i]  = (m_cnt[i] == cvi) && !m_c[i];
            m_c[i]  = (m_cnt[i] == cvi);
            e_w[i]  = m_wp[i];
            m_wp[i] = 1'b0;
            d = 0;
            if (clr[i])
                m_cnt[i] = 0;
            else if (en[i]) begin
                if (up[i] && !dn[i])
                    d = 1;
                else if (dn[i] && !up[i])
                    d = -1;
                else if (!up[i] && !dn[i] && au[i] && m_tick)
                    d = 1;
            end
            if (d != 0) begin
                nv = m_cnt[i] + d;
                if (nv > MAXV || nv < 0) begin
                    m_wp[i] = 1'b1;
`ifndef COUNTER_BANK_SATURATE_EN
                    m_cnt[i] = (nv < 0) ? MAXV : 0;
`endif
                end else
                    m_cnt[i] = nv;
            end
            e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
        end
        edge_n++;
        e_t = (edge_n == next_tick);
        if (e_t)
            next_tick = edge_n + int'(div_period) + 1;
        m_tick = e_t;
        exp_q.push_back({e_cnt, e_t, e_z, e_c, e_w});
        @(posedge sys_clk);
        #3;
    endtask

    task automatic do_reset(input logic [DW-1:0] dp);
        reset = 1'b1;
        div_period = dp;
        ch_clr = '0; ch_en = '0; ch_up = '0; ch_down = '0; ch_auto = '0; cmp_val = '1;
        exp_q.delete();
        model_reset();
        @(posedge sys_clk);
        #1;
        check("reset_count", count, 0);
        check("reset_tick", tick, 0);
        check("reset_pulses", {zero_pulse, cmp_pulse, wrap_pulse}, 0);
        @(posedge sys_clk);
        #3;
        reset = 1'b0;
    endtask

    // Monitor: every cycle the DUT presents a new state; pop and compare one entry.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!reset && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count", count, e[W-1 -: NCH*CW]);
                check("tick", tick, e[3*NCH]);
                check("zero_pulse", zero_pulse, e[3*NCH-1 -: NCH]);
                check("cmp_pulse", cmp_pulse, e[2*NCH-1 -: NCH]);
                check("wrap_pulse", wrap_pulse, e[NCH-1:0]);
            end
        end
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [NCH-1:0]    r_clr, r_en, r_up, r_dn, r_au;
        logic [NCH*CW-1:0] cv;
        logic [NCH-1:0]    n0;
        logic [NCH-1:0]    a0;
        n0 = '0;
        a0 = '1;

        // Divide-by-4 auto count on channel 0: five ticks land in 20 cycles.
        do_reset(24'd3);
        for (int k = 0; k < 20; k++)
            step(n0, 4'b0001, n0, n0, 4'b0001, '1);
        check("auto_count_20", count[CW-1:0], 8'd5);

        // Wrap (or saturate) at the top of the range.
        step(4'b0001, a0, n0, n0, n0, '1);
        for (int k = 0; k < MAXV; k++)
            step(n0, a0, 4'b0001, n0, n0, '1);
        check("at_max", count[CW-1:0], 8'hFF);
        step(n0, a0, 4'b0001, n0, n0, '1);
`ifdef COUNTER_BANK_SATURATE_EN
        check("inc_at_max", count[CW-1:0], 8'hFF);
`else
        check("inc_at_max", count[CW-1:0], 8'h00);
`endif
        step(n0, a0, n0, n0, n0, '1);
        step(n0, a0, n0, n0, n0, '1);
        // Decrement below zero from a cleared channel.
        step(4'b0001, a0, n0, n0, n0, '1);
        step(n0, a0, n0, 4'b0001, n0, '1);
        step(n0, a0, n0, n0, n0, '1);
        step(n0, a0, n0, n0, n0, '1);

        // Up/down collision holds; clear beats up.
        step(4'b0001, a0, n0, n0, n0, '1);
        for (int k = 0; k < 16; k++)
            step(n0, a0, 4'b0001, n0, n0, '1);
        step(n0, a0, 4'b0001, 4'b0001, n0, '1);
        check("up_down_hold", count[CW-1:0], 8'h10);
        step(4'b0001, a0, 4'b0001, n0, n0, '1);
        check("clr_beats_up", count[CW-1:0], 8'h00);

        // Compare edge: reach 5 with pulses, step off and back on.
        cv = {NCH{8'hFF}};
        cv[CW-1:0] = 8'h05;
        for (int k = 0; k < 5; k++) begin
            step(n0, a0, 4'b0001, n0, n0, cv);
            step(n0, a0, n0, n0, n0, cv);
        end
        step(n0, a0, n0, 4'b0001, n0, cv);
        step(n0, a0, 4'b0001, n0, n0, cv);
        step(n0, a0, n0, n0, n0, cv);
        step(n0, a0, n0, n0, n0, cv);
        // cmp_val moving onto the count.
        cv[2*CW-1 -: CW] = 8'h00;
        step(n0, a0, n0, n0, n0, cv);
        cv[2*CW-1 -: CW] = 8'h07;
        step(n0, a0, n0, n0, n0, cv);
        cv[2*CW-1 -: CW] = 8'h00;
        step(n0, a0, n0, n0, n0, cv);
        step(n0, a0, n0, n0, n0, cv);

        // Disabled channel freezes against up and auto; clear still works.
        div_period = 24'd0;
        for (int k = 0; k < 6; k++)
            step(n0, n0, 4'b0011, n0, a0, '1);
        step(4'b0001, n0, n0, n0, a0, '1);
        step(n0, n0, n0, n0, a0, '1);
        step(n0, n0, n0, n0, a0, '1);

        // Randomized traffic, with occasional divider and compare-value changes.
        cv = '0;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 49) == 0)
                div_period = DW'($urandom_range(0, 4));
            for (int i = 0; i < NCH; i++) begin
                r_clr[i] = ($urandom_range(0, 39) == 0);
                r_en[i]  = ($urandom_range(0, 7) != 0);
                r_up[i]  = ($urandom_range(0, 2) == 0);
                r_dn[i]  = ($urandom_range(0, 2) == 0);
                r_au[i]  = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 29) == 0)
                    cv[i*CW +: CW] = CW'($urandom_range(0, 6));
                else if ($urandom_range(0, 99) == 0)
                    cv[i*CW +: CW] = CW'(MAXV - $urandom_range(0, 2));
            end
            step(r_clr, r_en, r_up, r_dn, r_au, cv);
        end

        // Asynchronous reset mid-period with channel 0 at 0x42.
        do_reset(24'd2);
        for (int k = 0; k < 66; k++)
            step(n0, a0, 4'b0001, n0, 4'b1110, '1);
        check("pre_reset_count", count[CW-1:0], 8'h42);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_count", count, 0);
        check("async_reset_tick", tick, 0);
        check("async_reset_pulses", {zero_pulse, cmp_pulse, wrap_pulse}, 0);
        do_reset(24'd2);
        for (int k = 0; k < 8; k++)
            step(n0, a0, n0, n0, n0, '1);

        @(posedge sys_clk);
        #3;
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
